// File: rtl/lsu_pkg.sv
// Shared encodings, state type and legality helper for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StBusReq,
        StBusWait,
        StDone
    } lsu_state_e;

    // Unsigned variants only exist for loads; the remaining codes are unused.
    function automatic logic memop_legal(input logic [2:0] op, input logic is_store);
        logic legal;
        case (op)
            MEMOP_B, MEMOP_H, MEMOP_W: legal = 1'b1;
            MEMOP_BU, MEMOP_HU:        legal = !is_store;
            default:                   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Selects the addressed byte/half/word from a bus read word and extends it.
module lsu_load_ext (
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  MemOp,
    output logic [31:0] ext_data
);
    import lsu_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by sign or zero extension by access type
    always_comb begin
        byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
        half_sel = mem_rdata[{addr_lo[1], 4'b0000} +: 16];
        case (MemOp)
            MEMOP_B:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_H:  ext_data = {{16{half_sel[15]}}, half_sel};
            MEMOP_BU: ext_data = {24'b0, byte_sel};
            MEMOP_HU: ext_data = {16'b0, half_sel};
            default:  ext_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store unit: runs one data-memory bus transaction per accepted request.
module lsu_mem_access #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  MemOp,
    input  logic        MemWr,
    input  logic        MemtoReg,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    import lsu_pkg::*;

    // Counter value on the last permitted cycle of a wait state
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    lsu_state_e      state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [2:0]      op_q, op_d;
    logic            store_q, store_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            accept_err;
    logic [3:0]      lane_mask;
    logic [31:0]     lane_data;
    logic [31:0]     ext_data;

    lsu_load_ext u_load_ext (
        .mem_rdata (mem_rdata),
        .addr_lo   (addr_q[1:0]),
        .MemOp     (op_q),
        .ext_data  (ext_data)
    );

    // Request-time error decode on the live request fields
    always_comb begin
        accept_err = 1'b0;
        if (MemWr == MemtoReg) begin
            accept_err = 1'b1;
        end else if (!memop_legal(MemOp, MemWr)) begin
            accept_err = 1'b1;
        end else if (MemOp[1:0] == 2'b01 && addr[0]) begin
            accept_err = 1'b1;
        end else if (MemOp[1:0] == 2'b10 && addr[1:0] != 2'b00) begin
            accept_err = 1'b1;
        end
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        lane_mask = 4'b0000;
        lane_data = 32'h0;
        if (store_q) begin
            case (op_q[1:0])
                2'b00: begin
                    lane_mask = 4'b0001 << addr_q[1:0];
                    lane_data = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
                    lane_data = {2{wdata_q[15:0]}};
                end
                default: begin
                    lane_mask = 4'b1111;
                    lane_data = wdata_q;
                end
            endcase
        end
    end

    // Outputs decoded from state; bus fields are zero outside the request phase
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StDone);
        resp_err   = resp_valid & err_q;
        rdata      = resp_valid ? rdata_q : 32'h0;
        mem_valid  = (state_q == StBusReq);
        mem_addr   = mem_valid ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_wen    = mem_valid & store_q;
        mem_wmask  = mem_valid ? lane_mask : 4'b0000;
        mem_wdata  = mem_valid ? lane_data : 32'h0;
    end

    // Next-state: accept, bus handshake, read return and timeout
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        op_d     = op_q;
        store_d  = store_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d     = MemOp;
                    store_d  = MemWr;
                    addr_d   = addr;
                    wdata_d  = wdata;
                    rdata_d  = 32'h0;
                    to_cnt_d = '0;
                    err_d    = accept_err;
                    state_d  = accept_err ? StDone : StBusReq;
                end
            end
            StBusReq: begin
                if (mem_ready) begin
                    to_cnt_d = '0;
                    state_d  = store_q ? StDone : StBusWait;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StBusWait: begin
                if (mem_rvalid) begin
                    rdata_d = ext_data;
                    state_d = StDone;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            to_cnt_q <= '0;
            op_q     <= 3'b000;
            store_q  <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            op_q     <= op_d;
            store_q  <= store_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule
